// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Command-side initiator for the 16-bit registered ALU. Takes one
//             operation at a time on a valid/ready command port, drives the
//             ALU operand/function inputs, waits out the ALU's one-cycle
//             registered latency, captures result and carry, and returns
//             them on a valid/ready response port. Divide-by-zero and the
//             unused opcode 1111 are trapped locally without touching the ALU.
//  Ports    :
//    CLK, RST              clock (rising edge), async active-high reset
//    CMD_VALID/READY       command handshake
//    CMD_OP, CMD_A, CMD_B  function code and operands
//    ALU_A, ALU_B, ALU_FUN registered operands/function to the ALU
//    ALU_OUT, ALU_CARRY    ALU registered result and carry flag
//    RSP_VALID/READY       response handshake
//    RSP_DATA, RSP_CARRY   result, carry (add/sub only)
//    RSP_ERR               divide-by-zero or unused opcode
//    OP_CNT                completed-response counter (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [3:0]        CMD_OP,
    input  logic [DATA_W-1:0] CMD_A,
    input  logic [DATA_W-1:0] CMD_B,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [3:0]        ALU_FUN,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic              ALU_CARRY,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_CARRY,
    output logic              RSP_ERR,
    output logic [CNT_W-1:0]  OP_CNT
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_issue   = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_resp    = 2'd3;

    localparam logic [3:0] c_fun_add  = 4'b0000;
    localparam logic [3:0] c_fun_sub  = 4'b0001;
    localparam logic [3:0] c_fun_div  = 4'b0011;
    localparam logic [3:0] c_fun_park = 4'b1111;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_fun;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_carry;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_op_cnt;

    logic w_accept;
    logic w_trap_unused;
    logic w_trap_div0;
    logic w_trap;
    logic w_fun_has_carry;

    // Ready comes from the state register alone so it never depends
    // combinationally on CMD_VALID.
    assign CMD_READY = (r_state == c_st_idle);
    assign RSP_VALID = (r_state == c_st_resp);

    assign w_accept      = CMD_VALID && CMD_READY;
    assign w_trap_unused = (CMD_OP == c_fun_park);
    assign w_trap_div0   = (CMD_OP == c_fun_div) && (CMD_B == '0);
    assign w_trap        = w_trap_unused || w_trap_div0;

    // The ALU only updates its carry flag for add/sub; for anything else
    // the flag is left over from an earlier operation.
    assign w_fun_has_carry = (r_alu_fun == c_fun_add) || (r_alu_fun == c_fun_sub);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = w_trap ? c_st_resp : c_st_issue;
                end
            end
            // ALU samples its inputs at the end of ISSUE; its registered
            // result is visible during CAPTURE.
            c_st_issue:   w_state_next = c_st_capture;
            c_st_capture: w_state_next = c_st_resp;
            c_st_resp: begin
                if (RSP_READY) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: ALU drive, response capture, completion counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= c_fun_park;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_trap_unused) begin
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_carry <= 1'b0;
                        end else if (w_trap_div0) begin
                            r_rsp_data  <= '1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_carry <= 1'b0;
                        end else begin
                            r_alu_a   <= CMD_A;
                            r_alu_b   <= CMD_B;
                            r_alu_fun <= CMD_OP;
                        end
                    end
                end
                c_st_capture: begin
                    r_rsp_data  <= ALU_OUT;
                    r_rsp_carry <= w_fun_has_carry ? ALU_CARRY : 1'b0;
                    r_rsp_err   <= 1'b0;
                    // Park the function code; operands keep their values.
                    r_alu_fun   <= c_fun_park;
                end
                c_st_resp: begin
                    if (RSP_READY) begin
                        r_op_cnt <= r_op_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_CARRY = r_rsp_carry;
    assign RSP_ERR   = r_rsp_err;
    assign OP_CNT    = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Self-checking bench for alu_op_sequencer. Contains a behavioural
//             registered ALU, a transaction-level model of the sequencer and
//             a per-cycle compare process, plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [3:0]        CMD_OP;
    logic [DATA_W-1:0] CMD_A;
    logic [DATA_W-1:0] CMD_B;
    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_B;
    logic [3:0]        ALU_FUN;
    logic [DATA_W-1:0] ALU_OUT   = '0;
    logic              ALU_CARRY = 1'b0;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_DATA;
    logic              RSP_CARRY;
    logic              RSP_ERR;
    logic [CNT_W-1:0]  OP_CNT;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_A     (CMD_A),
        .CMD_B     (CMD_B),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_FUN   (ALU_FUN),
        .ALU_OUT   (ALU_OUT),
        .ALU_CARRY (ALU_CARRY),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_CARRY (RSP_CARRY),
        .RSP_ERR   (RSP_ERR),
        .OP_CNT    (OP_CNT)
    );

    // Functional ALU: returns {carry, result}
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] r;
        logic [31:0] p;
        r = '0;
        p = '0;
        case (op)
            4'h0: r = {1'b0, a} + {1'b0, b};
            4'h1: r = {1'b0, a} - {1'b0, b};
            4'h2: begin p = a * b; r = {1'b0, p[15:0]}; end
            4'h3: r = (b == 16'h0) ? 17'h0FFFF : {1'b0, a / b};
            4'h4: r = {1'b0, a & b};
            4'h5: r = {1'b0, a | b};
            4'h6: r = {1'b0, a ^ b};
            4'h7: r = {1'b0, ~a};
            4'hB: r = (a > b) ? 17'd2 : ((a < b) ? 17'd1 : 17'd3);
            4'hE: r = {1'b0, a << b[3:0]};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    // Registered ALU with one-cycle latency; carry only moves on add/sub.
    always @(posedge CLK) begin
        if (ALU_FUN != 4'hF) begin
            ALU_OUT <= alu_f(ALU_FUN, ALU_A, ALU_B) & 17'h0FFFF;
            if (ALU_FUN <= 4'h1) ALU_CARRY <= alu_f(ALU_FUN, ALU_A, ALU_B) >> 16;
        end
    end

    function automatic logic is_trap(input logic [3:0] op, input logic [15:0] b);
        return (op == 4'hF) || (op == 4'h3 && b == 16'h0);
    endfunction

    // Expected {err, carry, data} for a command
    function automatic logic [17:0] exp_rsp(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] r;
        if (op == 4'hF) return {1'b1, 1'b0, 16'h0000};
        if (op == 4'h3 && b == 16'h0) return {1'b1, 1'b0, 16'hFFFF};
        r = alu_f(op, a, b);
        return {1'b0, (op <= 4'h1) ? r[16] : 1'b0, r[15:0]};
    endfunction

    // Transaction-level model: one command in flight, counted latency.
    logic             m_busy;
    int               m_rem;
    logic             m_issued;
    logic [3:0]       m_op;
    logic [15:0]      m_last_a, m_last_b, m_data;
    logic             m_carry, m_err;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy   <= 1'b0;
            m_rem    <= 0;
            m_issued <= 1'b0;
            m_op     <= 4'hF;
            m_last_a <= '0;
            m_last_b <= '0;
            m_data   <= '0;
            m_carry  <= 1'b0;
            m_err    <= 1'b0;
            m_cnt    <= '0;
        end else if (!m_busy) begin
            if (CMD_VALID) begin
                m_busy   <= 1'b1;
                m_issued <= !is_trap(CMD_OP, CMD_B);
                m_op     <= CMD_OP;
                {m_err, m_carry, m_data} <= exp_rsp(CMD_OP, CMD_A, CMD_B);
                if (!is_trap(CMD_OP, CMD_B)) begin
                    m_last_a <= CMD_A;
                    m_last_b <= CMD_B;
                    m_rem    <= 2;
                end else begin
                    m_rem <= 0;
                end
            end
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
        end else if (RSP_READY) begin
            m_busy <= 1'b0;
            m_cnt  <= m_cnt + 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge CLK) begin
        if (!RST) begin
            chk("cmd_ready", 32'(CMD_READY), 32'(!m_busy));
            chk("rsp_valid", 32'(RSP_VALID), 32'(m_busy && m_rem == 0));
            chk("alu_fun", 32'(ALU_FUN),
                (m_busy && m_issued && m_rem > 0) ? 32'(m_op) : 32'hF);
            chk("alu_a", 32'(ALU_A), 32'(m_last_a));
            chk("alu_b", 32'(ALU_B), 32'(m_last_b));
            chk("op_cnt", 32'(OP_CNT), 32'(m_cnt));
            if (m_busy && m_rem == 0) begin
                chk("rsp_data", 32'(RSP_DATA), 32'(m_data));
                chk("rsp_carry", 32'(RSP_CARRY), 32'(m_carry));
                chk("rsp_err", 32'(RSP_ERR), 32'(m_err));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int acc);
        logic got;
        got = 1'b0;
        acc = -100;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_A     = a;
        CMD_B     = b;
        for (int k = 0; k < 50 && !got; k++) begin
            if (CMD_READY) begin
                @(posedge CLK);
                #1;
                acc = cyc;
                got = 1'b1;
            end else begin
                @(posedge CLK);
                @(negedge CLK);
            end
        end
        CMD_VALID = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_accept_timeout: got no accept expected accept at %0t", $time);
        end
    endtask

    task automatic wait_rsp(input int acc, output logic [15:0] d, output logic c,
                            output logic e, output int lat);
        logic found;
        found = 1'b0;
        lat = -1;
        d = '0;
        c = 1'b0;
        e = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                lat   = cyc - acc + 1;
                d     = RSP_DATA;
                c     = RSP_CARRY;
                e     = RSP_ERR;
                found = 1'b1;
            end
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: got no RSP_VALID expected RSP_VALID at %0t", $time);
        end
    endtask

    int          acc, acc2, hs, lat;
    logic        done2;
    logic [15:0] d;
    logic        c, e;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CMD_VALID = 1'b0;
        CMD_OP    = 4'h0;
        CMD_A     = '0;
        CMD_B     = '0;
        RSP_READY = 1'b1;
        done2     = 1'b0;
        RST       = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst_ready", 32'(CMD_READY), 32'h1);
        chk("rst_valid", 32'(RSP_VALID), 32'h0);
        chk("rst_fun", 32'(ALU_FUN), 32'hF);
        chk("rst_alu_a", 32'(ALU_A), 32'h0);
        chk("rst_data", 32'(RSP_DATA), 32'h0);
        chk("rst_err", 32'(RSP_ERR), 32'h0);
        chk("rst_cnt", 32'(OP_CNT), 32'h0);
        RST = 1'b0;

        // Add with carry out
        send(4'h0, 16'hFFFF, 16'h0001, acc);
        wait_rsp(acc, d, c, e, lat);
        chk("add_lat", 32'(lat), 32'd3);
        chk("add_data", 32'(d), 32'h0000);
        chk("add_carry", 32'(c), 32'h1);
        chk("add_err", 32'(e), 32'h0);
        @(posedge CLK); #1;
        chk("add_cnt", 32'(OP_CNT), 32'd1);

        // Divide by zero is trapped
        send(4'h3, 16'd100, 16'd0, acc);
        wait_rsp(acc, d, c, e, lat);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_data", 32'(d), 32'hFFFF);
        chk("div0_err", 32'(e), 32'h1);
        chk("div0_carry", 32'(c), 32'h0);
        chk("div0_fun", 32'(ALU_FUN), 32'hF);
        @(posedge CLK); #1;
        chk("div0_cnt", 32'(OP_CNT), 32'd2);

        // Back-pressure with a second command waiting
        RSP_READY = 1'b0;
        send(4'h4, 16'hF0F0, 16'hFF00, acc);
        fork
            begin
                int a2;
                send(4'h0, 16'd1, 16'd2, a2);
                acc2  = a2;
                done2 = 1'b1;
            end
        join_none
        wait_rsp(acc, d, c, e, lat);
        chk("and_lat", 32'(lat), 32'd3);
        chk("and_data", 32'(d), 32'hF000);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_data", 32'(RSP_DATA), 32'hF000);
            chk("bp_ready", 32'(CMD_READY), 32'h0);
            chk("bp_valid", 32'(RSP_VALID), 32'h1);
            if (i == 4) RSP_READY = 1'b1;
        end
        @(posedge CLK); #1;
        hs = cyc;
        chk("bp_cnt", 32'(OP_CNT), 32'd3);
        for (int k = 0; k < 20 && !done2; k++) @(negedge CLK);
        if (!done2) begin
            n_vec++;
            n_err++;
            $display("FAIL bp_second_cmd: got not accepted expected accepted at %0t", $time);
        end else begin
            chk("bp_accept_gap", 32'(acc2 - hs), 32'd1);
            wait_rsp(acc2, d, c, e, lat);
            chk("bp2_data", 32'(d), 32'd3);
            chk("bp2_carry", 32'(c), 32'h0);
        end

        // Compare after an add that left carry=1
        send(4'h0, 16'hFFFF, 16'hFFFF, acc);
        wait_rsp(acc, d, c, e, lat);
        chk("add2_data", 32'(d), 32'hFFFE);
        chk("add2_carry", 32'(c), 32'h1);
        send(4'hB, 16'd5, 16'd3, acc);
        wait_rsp(acc, d, c, e, lat);
        chk("cmp_data", 32'(d), 32'd2);
        chk("cmp_carry", 32'(c), 32'h0);
        chk("cmp_stale_alu_carry", 32'(ALU_CARRY), 32'h1);

        // Reset during CAPTURE
        send(4'h2, 16'd3, 16'd4, acc);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(CMD_READY), 32'h1);
        chk("mid_rst_valid", 32'(RSP_VALID), 32'h0);
        chk("mid_rst_fun", 32'(ALU_FUN), 32'hF);
        chk("mid_rst_alu_a", 32'(ALU_A), 32'h0);
        chk("mid_rst_alu_b", 32'(ALU_B), 32'h0);
        chk("mid_rst_data", 32'(RSP_DATA), 32'h0);
        chk("mid_rst_cnt", 32'(OP_CNT), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("post_rst_no_valid", 32'(RSP_VALID), 32'h0);
        end
        send(4'h0, 16'd3, 16'd4, acc);
        wait_rsp(acc, d, c, e, lat);
        chk("post_rst_data", 32'(d), 32'd7);
        @(posedge CLK); #1;
        chk("post_rst_cnt", 32'(OP_CNT), 32'd1);

        // Mixed traffic up to the counter wrap
        for (int i = 1; i <= 254; i++) begin
            send(4'(i % 16), 16'(i * 4951), 16'(i % 5), acc);
            wait_rsp(acc, d, c, e, lat);
        end
        send(4'hF, 16'h1234, 16'h5678, acc);
        wait_rsp(acc, d, c, e, lat);
        chk("unused_lat", 32'(lat), 32'd1);
        chk("unused_data", 32'(d), 32'h0);
        chk("unused_err", 32'(e), 32'h1);
        @(posedge CLK); #1;
        chk("wrap_cnt", 32'(OP_CNT), 32'h0);

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side initiator for the 16-bit registered ALU. Accepts one operation at a time over a valid/ready command port and drives the ALU operand and function inputs. It waits out the ALU's one-cycle registered latency, captures the result and carry, and returns them over a valid/ready response port. Divide-by-zero and the unused opcode are trapped locally; the ALU is not exercised for either.

Parameters:
DATA_W, 16, operand/result width; must match the ALU.
CNT_W, 8, width of the completed-operation counter.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command
CMD_OP  in  4  ALU function code (0000 add … 1110 shift, 1111 unused)
CMD_A  in  DATA_W  operand A
CMD_B  in  DATA_W  operand B
ALU_A  out  DATA_W  registered operand A to ALU
ALU_B  out  DATA_W  registered operand B to ALU
ALU_FUN  out  4  registered function code to ALU
ALU_OUT  in  DATA_W  ALU registered result
ALU_CARRY  in  1  ALU carry flag
RSP_VALID  out  1  response present
RSP_READY  in  1  consumer accepts response
RSP_DATA  out  DATA_W  result
RSP_CARRY  out  1  carry for add/sub, else 0
RSP_ERR  out  1  1 = div-by-zero or opcode 1111
OP_CNT  out  CNT_W  count of completed responses

Behaviour:
- Clock and reset: single clock CLK. RST is asynchronous and active-high. On RST: state=IDLE, ALU_A=0, ALU_B=0, ALU_FUN=4'b1111, RSP_VALID=0, RSP_DATA=0, RSP_CARRY=0, RSP_ERR=0, OP_CNT=0.
- CMD_READY = (state==IDLE). It is decoded from the state register only, never from CMD_VALID.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - ALU_FUN parked at 1111; ALU_A and ALU_B hold their last values.
  - On CMD_VALID&&CMD_READY:
    - CMD_OP==1111 -> RSP_DATA=0, RSP_ERR=1, RSP_CARRY=0, go to RESP.
    - CMD_OP==0011 && CMD_B==0 -> RSP_DATA=16'hFFFF, RSP_ERR=1, RSP_CARRY=0, go to RESP.
    - Otherwise -> ALU_A=CMD_A, ALU_B=CMD_B, ALU_FUN=CMD_OP, go to ISSUE.
- ISSUE: ALU inputs held stable for one cycle; the ALU registers its result at the closing edge. Next state is CAPTURE.
- CAPTURE:
  - ALU inputs are still held.
  - At the closing edge: RSP_DATA=ALU_OUT; RSP_CARRY=ALU_CARRY if ALU_FUN is 0000 or 0001, else 0; RSP_ERR=0.
  - ALU_FUN returns to 1111. Next state is RESP.
- RESP: RSP_VALID=1. RSP_DATA, RSP_CARRY and RSP_ERR are held until RSP_READY. On RSP_VALID&&RSP_READY: RSP_VALID=0, OP_CNT+=1 (wraps modulo 2^CNT_W), go to IDLE.
- Latency, measured as command-accept edge to RSP_VALID high:
  - Issued ops: 3 edges.
  - Trapped ops: 1 edge.
  - Minimum command-to-command spacing is 4 cycles (issued) or 2 cycles (trapped) with RSP_READY tied high.
- Commands presented while CMD_READY=0 are ignored and not latched; the source must hold them.
- RSP_READY asserted while RSP_VALID=0 has no effect.
- Width rules:
  - RSP_DATA is the ALU's 16-bit result unmodified; multiply is the truncated low 16 bits.
  - Compare results are 1, 2 or 3 (or 0) exactly as returned by the ALU.
  - Only add/sub carry is reported, because ALU_CARRY is stale for other ops.
- RST asserted mid-operation (ISSUE/CAPTURE/RESP) drops the in-flight command and any pending response. No response is produced for it and OP_CNT is not incremented.

Test Plan:
- Add: CMD A=16'hFFFF, B=16'h0001, OP=0000; RSP_READY=1 -> RSP_VALID 3 edges after accept, RSP_DATA=0000, RSP_CARRY=1, RSP_ERR=0, OP_CNT=1.
- Divide by zero: OP=0011, A=100, B=0 -> RSP_VALID 1 edge after accept, RSP_DATA=FFFF, RSP_ERR=1. ALU_FUN never leaves 1111.
- Back-pressure: OP=0100, A=F0F0, B=FF00, RSP_READY low 5 cycles -> RSP_DATA=F000 held stable, CMD_READY=0 throughout. A second command presented during this window is not accepted until 1 cycle after the response handshake.
- Compare and stale carry: OP=1011, A=5, B=3 issued after an add that produced carry=1 -> RSP_DATA=2, RSP_CARRY=0.
- Reset mid-op: accept OP=0010, A=3, B=4; assert RST in CAPTURE -> all outputs at reset values, no RSP_VALID. The next command completes normally with OP_CNT=1.
- Counter wrap and unused opcode: CNT_W=8, complete 256 ops -> OP_CNT=0. OP=1111 -> RSP_DATA=0, RSP_ERR=1.
